// File: rtl/cacheline_adapter_pkg.sv
// cacheline_adapter_pkg: shared widths, derived burst constants, state encoding and address alignment
package cacheline_adapter_pkg;
  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int COUNT_WIDTH = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns one cache-line read/write request into a BEATS-long memory burst
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);
  state_e                 state;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] next;
  logic                   last;
  logic [BURST_WIDTH-1:0] beat [BEATS];
  logic [LINE_WIDTH-1:0]  rd_line;
  assign last = count == COUNT_WIDTH'(BEATS - 1);
  assign next = count + 1'b1;
  // full read line with the beat arriving this cycle merged in, so line_o can load on the last beat
  always_comb begin
    for (int i = 0; i < BEATS; i++)
      rd_line[i*BURST_WIDTH +: BURST_WIDTH] = (COUNT_WIDTH'(i) == count) ? burst_i : beat[i];
  end
  // request/burst sequencer; every output is registered and an aborted burst leaves no trace
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      for (int i = 0; i < BEATS; i++) beat[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            for (int i = 0; i < BEATS; i++) beat[i] <= line_i[i*BURST_WIDTH +: BURST_WIDTH];
            burst_o   <= line_i[BURST_WIDTH-1:0];
            address_o <= line_align(address_i);
            write_o   <= 1'b1;
            state     <= WRITE;
          end else if (read_i) begin
            address_o <= line_align(address_i);
            read_o    <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            beat[count] <= burst_i;
            count       <= last ? count : next;
            if (last) begin
              line_o <= rd_line;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            count   <= last ? count : next;
            burst_o <= last ? '0 : beat[next];
            if (last) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          resp_o <= 1'b0;
          count  <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: randomized line requests against a behavioural memory/line model
module tb_cacheline_adapter;
  import cacheline_adapter_pkg::*;
  logic                   clk = 1'b0;
  logic                   rst;
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;
  int                     checks = 0;
  int                     errors = 0;
  logic [LINE_WIDTH-1:0]  exp_line;
  cacheline_adapter dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  // one arbiter request serviced by a memory that strobes beats per pattern or at random
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr, input logic [255:0] wline,
                         input logic [255:0] rline, input int gap_pct, input logic [15:0] pat, input int pat_len);
    logic [255:0] cap = '0;
    logic [31:0]  exp_addr = addr & ~32'h1F;
    int           k = 0;
    int           cyc = 0;
    write_i   = wr;
    read_i    = rd;
    address_i = addr;
    line_i    = wline;
    resp_i    = 1'b0;
    while (k < BEATS && cyc < 200) begin
      @(negedge clk);
      check("resp_o_mid", resp_o, 1'b0);
      check("address_o", address_o, exp_addr);
      check("read_o", read_o, !wr);
      check("write_o", write_o, wr);
      address_i = $urandom;
      line_i    = rnd256();
      resp_i    = (cyc < pat_len) ? pat[cyc] : ($urandom_range(99) >= gap_pct);
      burst_i   = {$urandom, $urandom};
      if (resp_i) begin
        if (wr) cap[k*64 +: 64] = burst_o;
        else burst_i = rline[k*64 +: 64];
        k++;
      end
      cyc++;
    end
    check("beats_taken", k, BEATS);
    @(negedge clk);
    resp_i  = 1'b0;
    read_i  = 1'b0;
    write_i = 1'b0;
    if (!wr) exp_line = rline;
    check("resp_o_pulse", resp_o, 1'b1);
    check("read_o_end", read_o, 1'b0);
    check("write_o_end", write_o, 1'b0);
    check("line_o", line_o, exp_line);
    if (wr) check("write_data", cap, wline);
    @(negedge clk);
    check("resp_o_single", resp_o, 1'b0);
    check("line_o_hold", line_o, exp_line);
  endtask
  initial begin
    logic [255:0] a, b;
    bit           w;
    rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0; burst_i = '0; line_i = '0; address_i = '0;
    exp_line = '0;
    #12;
    check("rst_line_o", line_o, '0);
    check("rst_burst_o", burst_o, '0);
    check("rst_address_o", address_o, '0);
    check("rst_ctrl", {read_o, write_o, resp_o}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(0, 1, 32'h0000_00A4, '0, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 16'h0, 0);
    run_txn(1, 0, 32'h1234_567F, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, '0, 0, 16'h0, 0);
    run_txn(0, 1, 32'h0000_1040, '0, rnd256(), 0, 16'b101_1001, 7);
    run_txn(1, 0, 32'hDEAD_BEEF, rnd256(), '0, 0, 16'h0, 0);
    run_txn(0, 1, 32'h0000_2000, '0, rnd256(), 0, 16'h0, 0);
    read_i = 1'b1;
    address_i = 32'h0000_3000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
    end
    @(negedge clk);
    resp_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_read_o", read_o, 1'b0);
    check("arst_resp_o", resp_o, 1'b0);
    check("arst_line_o", line_o, '0);
    exp_line = '0;
    read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_no_resp", resp_o, 1'b0);
    run_txn(0, 1, 32'h0000_3010, '0, rnd256(), 0, 16'h0, 0);
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      @(negedge clk);
      check("idle_spurious", {read_o, write_o, resp_o}, 3'b000);
      check("idle_line_o", line_o, exp_line);
    end
    resp_i = 1'b0;
    run_txn(1, 1, 32'h0000_4444, rnd256(), rnd256(), 0, 16'h0, 0);
    for (int n = 0; n < 20; n++) begin
      w = $urandom_range(1);
      a = rnd256();
      b = rnd256();
      run_txn(w, !w, $urandom, a, b, $urandom_range(60), 16'h0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
